// File: rtl/warp_issue_arbiter_if.sv
// Signal bundle around the warp issue arbiter: decode enqueue, scoreboard query/issue, execute issue.
// slave = arbiter side; master = the surrounding pipeline (decode, scoreboard, execute).
interface warp_issue_arbiter_if #(
  parameter int WARP_ID_WIDTH  = 2,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int PAYLOAD_WIDTH  = 64
);
  logic                      in_valid, in_ready;
  logic [WARP_ID_WIDTH-1:0]  in_warp_id;
  logic [REG_ADDR_WIDTH-1:0] in_rs1, in_rs2, in_rs3, in_rd;
  logic                      in_uses_rs1, in_uses_rs2, in_uses_rs3;
  logic                      in_reg_write, in_is_load;
  logic [PAYLOAD_WIDTH-1:0]  in_payload;

  logic                      sb_decode_valid;
  logic [WARP_ID_WIDTH-1:0]  sb_warp_id;
  logic [REG_ADDR_WIDTH-1:0] sb_rs1, sb_rs2, sb_rs3;
  logic                      sb_uses_rs1, sb_uses_rs2, sb_uses_rs3;
  logic                      sb_hazard, sb_rs1_hazard, sb_rs2_hazard, sb_rs3_hazard;
  logic                      sb_rs1_fwd_valid, sb_rs2_fwd_valid, sb_rs3_fwd_valid, sb_load_use;
  logic                      sb_issue;
  logic [WARP_ID_WIDTH-1:0]  sb_issue_warp_id;
  logic [REG_ADDR_WIDTH-1:0] sb_issue_rd;
  logic                      sb_issue_reg_write, sb_issue_is_load;

  logic                      flush;
  logic [WARP_ID_WIDTH-1:0]  flush_warp_id;

  logic                      iss_valid, iss_ready;
  logic [WARP_ID_WIDTH-1:0]  iss_warp_id;
  logic [REG_ADDR_WIDTH-1:0] iss_rd;
  logic                      iss_reg_write, iss_is_load;
  logic [PAYLOAD_WIDTH-1:0]  iss_payload;
  logic [31:0]               stall_cycles;

  modport slave (
    input  in_valid, in_warp_id, in_rs1, in_rs2, in_rs3, in_rd,
           in_uses_rs1, in_uses_rs2, in_uses_rs3, in_reg_write, in_is_load, in_payload,
           sb_hazard, sb_rs1_hazard, sb_rs2_hazard, sb_rs3_hazard,
           sb_rs1_fwd_valid, sb_rs2_fwd_valid, sb_rs3_fwd_valid, sb_load_use,
           flush, flush_warp_id, iss_ready,
    output in_ready, sb_decode_valid, sb_warp_id, sb_rs1, sb_rs2, sb_rs3,
           sb_uses_rs1, sb_uses_rs2, sb_uses_rs3,
           sb_issue, sb_issue_warp_id, sb_issue_rd, sb_issue_reg_write, sb_issue_is_load,
           iss_valid, iss_warp_id, iss_rd, iss_reg_write, iss_is_load, iss_payload, stall_cycles
  );

  modport master (
    output in_valid, in_warp_id, in_rs1, in_rs2, in_rs3, in_rd,
           in_uses_rs1, in_uses_rs2, in_uses_rs3, in_reg_write, in_is_load, in_payload,
           sb_hazard, sb_rs1_hazard, sb_rs2_hazard, sb_rs3_hazard,
           sb_rs1_fwd_valid, sb_rs2_fwd_valid, sb_rs3_fwd_valid, sb_load_use,
           flush, flush_warp_id, iss_ready,
    input  in_ready, sb_decode_valid, sb_warp_id, sb_rs1, sb_rs2, sb_rs3,
           sb_uses_rs1, sb_uses_rs2, sb_uses_rs3,
           sb_issue, sb_issue_warp_id, sb_issue_rd, sb_issue_reg_write, sb_issue_is_load,
           iss_valid, iss_warp_id, iss_rd, iss_reg_write, iss_is_load, iss_payload, stall_cycles
  );
endinterface

// File: rtl/warp_issue_arbiter.sv
// Per-warp instruction slots with round-robin issue gated by the hazard scoreboard.
// FORWARDING_EN: when defined, hazards covered by a forwarding path do not block issue.
module warp_issue_arbiter #(
  parameter int NUM_WARPS      = 4,
  parameter int WARP_ID_WIDTH  = 2,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int PAYLOAD_WIDTH  = 64
) (
  input logic                clk,
  input logic                rst_n,
  warp_issue_arbiter_if.slave bus
);
  typedef logic [WARP_ID_WIDTH-1:0] wid_t;
  typedef struct packed {
    logic [REG_ADDR_WIDTH-1:0] rs1, rs2, rs3;
    logic                      uses_rs1, uses_rs2, uses_rs3;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic                      reg_write, is_load;
    logic [PAYLOAD_WIDTH-1:0]  payload;
  } slot_t;

  slot_t                     slot_q [NUM_WARPS];
  logic [NUM_WARPS-1:0]      slot_valid;
  logic [NUM_WARPS-1:0]      flush_mask;
  slot_t                     in_slot, cand_slot;
  wid_t                      rr_ptr, cand, scan_idx;
  logic                      cand_valid, blocked, accept, enq;
  logic [31:0]               stall_q;
  logic                      iss_valid_q, iss_rw_q, iss_ld_q;
  wid_t                      iss_warp_q;
  logic [REG_ADDR_WIDTH-1:0] iss_rd_q;
  logic [PAYLOAD_WIDTH-1:0]  iss_pl_q;

  assign flush_mask = bus.flush ? (NUM_WARPS'(1) << bus.flush_warp_id) : '0;
  assign in_slot = {bus.in_rs1, bus.in_rs2, bus.in_rs3,
                    bus.in_uses_rs1, bus.in_uses_rs2, bus.in_uses_rs3,
                    bus.in_rd, bus.in_reg_write, bus.in_is_load, bus.in_payload};

  // Scan from the farthest offset down so the nearest valid warp after rr_ptr wins.
  always_comb begin
    cand       = rr_ptr;
    cand_valid = 1'b0;
    scan_idx   = rr_ptr;
    for (int i = NUM_WARPS - 1; i >= 0; i--) begin
      scan_idx = rr_ptr + wid_t'(i);
      if (slot_valid[scan_idx] && !flush_mask[scan_idx]) begin
        cand       = scan_idx;
        cand_valid = 1'b1;
      end
    end
  end

  assign cand_slot = slot_q[cand];

`ifdef FORWARDING_EN
  assign blocked = bus.sb_load_use
                 | (cand_slot.uses_rs1 & bus.sb_rs1_hazard & ~bus.sb_rs1_fwd_valid)
                 | (cand_slot.uses_rs2 & bus.sb_rs2_hazard & ~bus.sb_rs2_fwd_valid)
                 | (cand_slot.uses_rs3 & bus.sb_rs3_hazard & ~bus.sb_rs3_fwd_valid);
  logic unused_sb_hazard;
  assign unused_sb_hazard = bus.sb_hazard;
`else
  assign blocked = bus.sb_hazard | bus.sb_load_use;
  logic unused_fwd;
  assign unused_fwd = ^{bus.sb_rs1_hazard, bus.sb_rs2_hazard, bus.sb_rs3_hazard,
                        bus.sb_rs1_fwd_valid, bus.sb_rs2_fwd_valid, bus.sb_rs3_fwd_valid};
`endif

  assign accept = cand_valid && !blocked && (!iss_valid_q || bus.iss_ready);
  assign bus.in_ready = !slot_valid[bus.in_warp_id] && !flush_mask[bus.in_warp_id];
  assign enq = bus.in_valid && bus.in_ready;

  assign bus.sb_decode_valid    = cand_valid;
  assign bus.sb_warp_id         = cand;
  assign bus.sb_rs1             = cand_slot.rs1;
  assign bus.sb_rs2             = cand_slot.rs2;
  assign bus.sb_rs3             = cand_slot.rs3;
  assign bus.sb_uses_rs1        = cand_slot.uses_rs1;
  assign bus.sb_uses_rs2        = cand_slot.uses_rs2;
  assign bus.sb_uses_rs3        = cand_slot.uses_rs3;
  assign bus.sb_issue           = accept;
  assign bus.sb_issue_warp_id   = cand;
  assign bus.sb_issue_rd        = cand_slot.rd;
  assign bus.sb_issue_reg_write = cand_slot.reg_write;
  assign bus.sb_issue_is_load   = cand_slot.is_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_valid <= '0;
      for (int w = 0; w < NUM_WARPS; w++) slot_q[w] <= '0;
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        if (enq && bus.in_warp_id == wid_t'(w)) begin
          slot_valid[w] <= 1'b1;
          slot_q[w]     <= in_slot;
        end else if ((accept && cand == wid_t'(w)) || flush_mask[w]) begin
          slot_valid[w] <= 1'b0;
        end
      end
    end
  end

  // Pointer holds when the candidate is only waiting on execute backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr  <= '0;
      stall_q <= '0;
    end else begin
      if (cand_valid && (accept || blocked)) rr_ptr <= cand + wid_t'(1);
      if (cand_valid && blocked && stall_q != 32'hFFFF_FFFF) stall_q <= stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_valid_q <= 1'b0;
      iss_warp_q  <= '0;
      iss_rd_q    <= '0;
      iss_rw_q    <= 1'b0;
      iss_ld_q    <= 1'b0;
      iss_pl_q    <= '0;
    end else if (accept) begin
      iss_valid_q <= 1'b1;
      iss_warp_q  <= cand;
      iss_rd_q    <= cand_slot.rd;
      iss_rw_q    <= cand_slot.reg_write;
      iss_ld_q    <= cand_slot.is_load;
      iss_pl_q    <= cand_slot.payload;
    end else if (iss_valid_q && bus.iss_ready) begin
      iss_valid_q <= 1'b0;
    end else if (iss_valid_q && flush_mask[iss_warp_q]) begin
      iss_valid_q <= 1'b0;
      iss_warp_q  <= '0;
      iss_rd_q    <= '0;
      iss_rw_q    <= 1'b0;
      iss_ld_q    <= 1'b0;
      iss_pl_q    <= '0;
    end
  end

  assign bus.iss_valid     = iss_valid_q;
  assign bus.iss_warp_id   = iss_warp_q;
  assign bus.iss_rd        = iss_rd_q;
  assign bus.iss_reg_write = iss_rw_q;
  assign bus.iss_is_load   = iss_ld_q;
  assign bus.iss_payload   = iss_pl_q;
  assign bus.stall_cycles  = stall_q;
endmodule

// File: tb/tb_warp_issue_arbiter.sv
// Random stimulus against a slot/round-robin reference model; issued instructions are scoreboarded.
module tb_warp_issue_arbiter;
  localparam int NW = 4, WW = 2, RW = 5, PW = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  warp_issue_arbiter_if #(.WARP_ID_WIDTH(WW), .REG_ADDR_WIDTH(RW), .PAYLOAD_WIDTH(PW)) bus ();
  warp_issue_arbiter #(.NUM_WARPS(NW), .WARP_ID_WIDTH(WW), .REG_ADDR_WIDTH(RW), .PAYLOAD_WIDTH(PW))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [RW-1:0] rs1, rs2, rs3;
    logic          u1, u2, u3;
    logic [RW-1:0] rd;
    logic          rw, ld;
    logic [PW-1:0] pl;
  } instr_t;
  typedef struct {
    int            warp;
    logic [RW-1:0] rd;
    logic          rw, ld;
    logic [PW-1:0] pl;
  } issue_t;

  instr_t      m_slot [NW];
  bit          m_v [NW];
  int          m_rr, m_ow;
  bit          m_ov;
  logic [31:0] m_stall;
  issue_t      exp_q [$];
  int          total = 0, bad = 0;
  int          p_valid, p_haz, p_lu, p_ready, p_flush;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic roll(input int p);
    return $urandom_range(0, 99) < p;
  endfunction

  task automatic model_reset();
    for (int w = 0; w < NW; w++) m_v[w] = 1'b0;
    m_rr = 0; m_ov = 1'b0; m_ow = 0; m_stall = '0;
    exp_q.delete();
  endtask

  task automatic set_idle();
    bus.in_valid = 0; bus.in_warp_id = '0; bus.in_rs1 = '0; bus.in_rs2 = '0; bus.in_rs3 = '0;
    bus.in_rd = '0; bus.in_uses_rs1 = 0; bus.in_uses_rs2 = 0; bus.in_uses_rs3 = 0;
    bus.in_reg_write = 0; bus.in_is_load = 0; bus.in_payload = '0;
    bus.sb_hazard = 0; bus.sb_rs1_hazard = 0; bus.sb_rs2_hazard = 0; bus.sb_rs3_hazard = 0;
    bus.sb_rs1_fwd_valid = 0; bus.sb_rs2_fwd_valid = 0; bus.sb_rs3_fwd_valid = 0;
    bus.sb_load_use = 0; bus.flush = 0; bus.flush_warp_id = '0; bus.iss_ready = 0;
  endtask

  task automatic step();
    int fw, cand, iw;
    bit blocked, accept, exp_rdy;
    instr_t c;
    @(negedge clk);
    bus.in_valid     = roll(p_valid);
    bus.in_warp_id   = WW'($urandom_range(0, NW - 1));
    bus.in_rs1       = RW'($urandom);
    bus.in_rs2       = RW'($urandom);
    bus.in_rs3       = RW'($urandom);
    bus.in_rd        = RW'($urandom);
    bus.in_uses_rs1  = 1'($urandom_range(0, 1));
    bus.in_uses_rs2  = 1'($urandom_range(0, 1));
    bus.in_uses_rs3  = 1'($urandom_range(0, 1));
    bus.in_reg_write = 1'($urandom_range(0, 1));
    bus.in_is_load   = 1'($urandom_range(0, 1));
    bus.in_payload   = {$urandom, $urandom};
    bus.flush        = roll(p_flush);
    bus.flush_warp_id = WW'($urandom_range(0, NW - 1));
    bus.iss_ready    = roll(p_ready);
    bus.sb_rs1_hazard = roll(p_haz);
    bus.sb_rs2_hazard = roll(p_haz);
    bus.sb_rs3_hazard = roll(p_haz);
    bus.sb_rs1_fwd_valid = 1'($urandom_range(0, 1));
    bus.sb_rs2_fwd_valid = 1'($urandom_range(0, 1));
    bus.sb_rs3_fwd_valid = 1'($urandom_range(0, 1));
    bus.sb_hazard    = bus.sb_rs1_hazard | bus.sb_rs2_hazard | bus.sb_rs3_hazard;
    bus.sb_load_use  = roll(p_lu);
    #1;
    fw = bus.flush ? int'(bus.flush_warp_id) : -1;
    cand = -1;
    for (int k = 0; k < NW; k++) begin
      int w;
      w = (m_rr + k) % NW;
      if (cand < 0 && m_v[w] && w != fw) cand = w;
    end
    c = (cand >= 0) ? m_slot[cand] : m_slot[0];
`ifdef FORWARDING_EN
    blocked = bus.sb_load_use || (c.u1 && bus.sb_rs1_hazard && !bus.sb_rs1_fwd_valid)
              || (c.u2 && bus.sb_rs2_hazard && !bus.sb_rs2_fwd_valid)
              || (c.u3 && bus.sb_rs3_hazard && !bus.sb_rs3_fwd_valid);
`else
    blocked = bus.sb_hazard || bus.sb_load_use;
`endif
    iw = int'(bus.in_warp_id);
    exp_rdy = !m_v[iw] && (iw != fw);
    accept = (cand >= 0) && !blocked && (!m_ov || bus.iss_ready);

    chk("in_ready", bus.in_ready, exp_rdy);
    chk("sb_decode_valid", bus.sb_decode_valid, cand >= 0);
    chk("sb_issue", bus.sb_issue, accept);
    chk("iss_valid", bus.iss_valid, m_ov);
    chk("stall_cycles", bus.stall_cycles, m_stall);
    if (cand >= 0) begin
      chk("sb_warp_id", bus.sb_warp_id, cand);
      chk("sb_srcs", {bus.sb_rs1, bus.sb_rs2, bus.sb_rs3}, {c.rs1, c.rs2, c.rs3});
      chk("sb_uses", {bus.sb_uses_rs1, bus.sb_uses_rs2, bus.sb_uses_rs3}, {c.u1, c.u2, c.u3});
    end
    if (accept) begin
      chk("sb_issue_warp_id", bus.sb_issue_warp_id, cand);
      chk("sb_issue_fields", {bus.sb_issue_rd, bus.sb_issue_reg_write, bus.sb_issue_is_load},
          {c.rd, c.rw, c.ld});
    end

    if (cand >= 0 && (accept || blocked)) m_rr = (cand + 1) % NW;
    if (cand >= 0 && blocked && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
    if (accept) begin
      m_v[cand] = 1'b0;
      exp_q.push_back('{cand, c.rd, c.rw, c.ld, c.pl});
    end
    if (fw >= 0) m_v[fw] = 1'b0;
    if (bus.in_valid && exp_rdy) begin
      m_v[iw] = 1'b1;
      m_slot[iw] = '{bus.in_rs1, bus.in_rs2, bus.in_rs3, bus.in_uses_rs1, bus.in_uses_rs2,
                     bus.in_uses_rs3, bus.in_rd, bus.in_reg_write, bus.in_is_load, bus.in_payload};
    end
    if (accept) begin
      m_ov = 1'b1; m_ow = cand;
    end else if (m_ov && bus.iss_ready) begin
      m_ov = 1'b0;
    end else if (m_ov && fw == m_ow) begin
      m_ov = 1'b0;
      if (exp_q.size() > 0) exp_q.delete(exp_q.size() - 1);
    end
  endtask

  // Each completed execute handshake retires the oldest expected issue.
  always @(negedge clk) begin : monitor
    issue_t e;
    #2;
    if (rst_n && bus.iss_valid && bus.iss_ready) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL iss_unexpected: got warp %0d expected no issue", bus.iss_warp_id);
      end else begin
        e = exp_q.pop_front();
        chk("iss_warp_id", bus.iss_warp_id, e.warp);
        chk("iss_rd", bus.iss_rd, e.rd);
        chk("iss_flags", {bus.iss_reg_write, bus.iss_is_load}, {e.rw, e.ld});
        chk("iss_payload", bus.iss_payload, e.pl);
      end
    end
  end

  task automatic phase(input int v, input int h, input int l, input int r, input int f, input int n);
    p_valid = v; p_haz = h; p_lu = l; p_ready = r; p_flush = f;
    repeat (n) step();
  endtask

  initial begin
    set_idle();
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_iss_valid", bus.iss_valid, 1'b0);
    chk("rst_iss_fields", {bus.iss_warp_id, bus.iss_rd, bus.iss_reg_write, bus.iss_is_load}, '0);
    chk("rst_iss_payload", bus.iss_payload, '0);
    chk("rst_sb_issue", bus.sb_issue, 1'b0);
    chk("rst_sb_decode_valid", bus.sb_decode_valid, 1'b0);
    chk("rst_stall_cycles", bus.stall_cycles, '0);
    @(negedge clk);
    rst_n = 1'b1;

    phase(80, 0, 0, 100, 0, 400);
    phase(60, 15, 8, 70, 8, 1500);
    phase(70, 10, 5, 25, 15, 800);
    phase(40, 30, 30, 90, 5, 400);

    @(negedge clk);
    rst_n = 1'b0;
    set_idle();
    #1;
    chk("midrst_iss_valid", bus.iss_valid, 1'b0);
    chk("midrst_stall_cycles", bus.stall_cycles, '0);
    chk("midrst_in_ready", bus.in_ready, 1'b1);
    chk("midrst_sb_decode_valid", bus.sb_decode_valid, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    phase(60, 15, 8, 70, 8, 500);
    phase(0, 0, 0, 100, 0, 20);
    chk("drain_pending", exp_q.size(), 0);
    chk("drain_iss_valid", bus.iss_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/warp_issue_arbiter.md
# warp_issue_arbiter

Issue stage between warp decode and execute. Holds one decoded instruction per warp and picks a candidate warp each cycle by round-robin. It queries the hazard scoreboard combinationally for that candidate, then either issues it into a registered issue slot or marks it blocked and moves on. It drives the scoreboard's issue/set-pending port and consumes its hazard, forwarding and load-use outputs.

## Interface
Parameters:
- NUM_WARPS, 4, warps per core (power of two)
- WARP_ID_WIDTH, 2, log2(NUM_WARPS)
- REG_ADDR_WIDTH, 5, register index width
- PAYLOAD_WIDTH, 64, opaque decoded-instruction payload carried to execute

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid / in_ready  in / out  1 / 1  decode enqueue handshake
- in_warp_id  in  WARP_ID_WIDTH  target slot
- in_rs1, in_rs2, in_rs3  in  REG_ADDR_WIDTH each  sources
- in_uses_rs1/2/3  in  1 each  source-used flags
- in_rd  in  REG_ADDR_WIDTH  destination
- in_reg_write, in_is_load  in  1 each  write and load flags
- in_payload  in  PAYLOAD_WIDTH  opaque payload
- sb_decode_valid  out  1  scoreboard query valid
- sb_warp_id  out  WARP_ID_WIDTH  query warp
- sb_rs1/2/3, sb_uses_rs1/2/3  out  sources of the candidate
- sb_hazard, sb_rs1/2/3_hazard, sb_rs1/2/3_fwd_valid, sb_load_use  in  1 each  scoreboard answers, same cycle
- sb_issue  out  1  set-pending strobe
- sb_issue_warp_id, sb_issue_rd, sb_issue_reg_write, sb_issue_is_load  out  fields for sb_issue
- flush, flush_warp_id  in  1 / WARP_ID_WIDTH  kill one warp
- iss_valid / iss_ready  out / in  1 / 1  execute handshake
- iss_warp_id, iss_rd, iss_reg_write, iss_is_load, iss_payload  out  registered issue fields
- stall_cycles  out  32  saturating blocked-cycle counter

## Operation
- **Slots:** slot_valid[w] plus stored fields. in_ready = !slot_valid[in_warp_id] && !(flush && flush_warp_id==in_warp_id). The cycle a slot is dequeued, in_ready stays low for that warp; there is no bypass.
- **Candidate selection:** the first w with slot_valid[w], scanning from rr_ptr upward with wrap. A warp being flushed this cycle is excluded. sb_decode_valid = candidate exists. sb_* source fields come from the candidate slot.
- **Blocked condition:** sb_load_use, OR any hazarded used source with rsN_hazard && !rsN_fwd_valid (see FORWARDING_EN).
- **Accept:** candidate && !blocked && (!iss_valid || iss_ready).
  - On accept: sb_issue=1 in the same cycle, with the candidate's rd, reg_write and is_load.
  - Slot cleared; output register loaded next edge.
- **rr_ptr:** becomes candidate+1 (mod NUM_WARPS) whenever a candidate exists, whether issued or blocked. It is unchanged with no candidate or when a candidate is held only by output backpressure. Blocked warps are retried on wrap.
- **stall_cycles:** +1 per cycle with a blocked candidate; saturates at 0xFFFF_FFFF.
- **Flush of warp f:**
  - Clears slot f.
  - Suppresses selection of f that cycle.
  - Clears the output register if it holds f and the iss handshake does not complete that cycle. A completing handshake is honoured.

## Timing
- Reset values: in_ready=1, iss_valid=0, all iss_* fields=0, sb_issue=0, sb_decode_valid=0, rr_ptr=0, stall_cycles=0, all slots invalid.
- Enqueue-to-iss_valid minimum latency: 2 cycles (edge 1 writes the slot, edge 2 writes the output register).
- iss_valid and its fields hold stable until iss_ready. Throughput is 1 instruction per cycle with iss_ready tied high.
- sb_* query and sb_issue are combinational from slot state and scoreboard inputs. No combinational path from in_* to iss_*.
- Reset mid-operation: all state returns to reset values immediately (asynchronous).

## Configuration
- **FORWARDING_EN defined:** a hazarded source with fwd_valid=1 does not block; only sb_load_use or an unforwardable hazard blocks.
- **FORWARDING_EN undefined:** any sb_hazard blocks; fwd_valid inputs are ignored.

## Test plan
- **Basic issue:** enqueue warp 2 (rs1=5, rd=7), no hazards, iss_ready=1 -> sb_issue pulses with rd=7 one cycle after enqueue; iss_valid=1 with iss_warp_id=2 the next cycle.
- **Round-robin:** slots 0, 1, 3 valid, no hazards -> issue order 0, 1, 3; rr_ptr ends at 0.
- **Blocked warp:** warp 0 has sb_rs1_hazard=1, fwd_valid=0; warp 1 clean -> warp 1 issues, stall_cycles=1, warp 0 retried after wrap. Under FORWARDING_EN with fwd_valid=1, warp 0 issues immediately.
- **Load-use:** sb_load_use=1 for 3 cycles with warp 0 as the only slot -> no issue, stall_cycles=3. Issue follows in the cycle the signal drops.
- **Backpressure:** iss_ready=0 for 4 cycles with a second warp ready -> outputs stable, no sb_issue, rr_ptr frozen, stall_cycles unchanged.
- **Flush:**
  - Flush warp 1 while it is in the output register with iss_ready=0 -> iss_valid=0 next cycle.
  - Enqueue and flush of warp 1 in the same cycle -> in_ready=0, slot stays empty.
